// File: rtl/rule110_pkg.sv
// Shared constants, command encoding and FSM state encoding for the rule110 host sequencer.
package rule110_pkg;

  localparam int CELLS_PER_BLOCK = 8;
  localparam int NUM_CELLS_DEF   = 224;
  localparam int ADDR_W          = 6;
  localparam int COUNT_W         = 16;

  typedef enum logic [1:0] {
    OP_LOAD      = 2'b00,
    OP_STEP      = 2'b01,
    OP_DUMP      = 2'b10,
    OP_STEP_DUMP = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_STEP_RUN  = 3'd2,
    ST_DUMP_ADDR = 3'd3,
    ST_DUMP_HOLD = 3'd4
  } state_e;

endpackage

// File: rtl/rule110_host_ctrl_if.sv
// Host-facing command/stream signals plus the automaton pin bundle.
interface rule110_host_ctrl_if;

  // Every stream (cmd, s, m) transfers on a cycle where valid && ready are both high;
  // a producer holds its payload stable and keeps valid high until that cycle.
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [1:0]                     cmd_op;
  logic [rule110_pkg::COUNT_W-1:0] cmd_count;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  logic busy;

  logic [7:0]                     ca_data_in;
  logic                           ca_we_n;
  logic                           ca_halt_n;
  logic [rule110_pkg::ADDR_W-1:0] ca_addr;
  logic [7:0]                     ca_data_out;

  rule110_pkg::state_e dbg_state;

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, s_data, s_valid, m_ready, ca_data_out,
    output cmd_ready, s_ready, m_data, m_valid, m_last, busy,
           ca_data_in, ca_we_n, ca_halt_n, ca_addr, dbg_state
  );

  modport master (
    output cmd_valid, cmd_op, cmd_count, s_data, s_valid, m_ready, ca_data_out,
    input  cmd_ready, s_ready, m_data, m_valid, m_last, busy,
           ca_data_in, ca_we_n, ca_halt_n, ca_addr, dbg_state
  );

endinterface

// File: rtl/rule110_block_seq.sv
// Block index counter shared by LOAD and DUMP; saturates at the last block.
module rule110_block_seq
  import rule110_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_CELLS_DEF / CELLS_PER_BLOCK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] idx_q, idx_d;

  assign last_o = (idx_q == ADDR_W'(NUM_BLOCKS - 1));
  assign idx_o  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i && !last_o) begin
      idx_d = idx_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/rule110_host_ctrl.sv
// Turns LOAD/STEP/DUMP commands and byte streams into registered rule110 pin sequences.
module rule110_host_ctrl
  import rule110_pkg::*;
#(
  parameter int NUM_CELLS = NUM_CELLS_DEF
) (
  input logic                clk,
  input logic                rst_n,
  rule110_host_ctrl_if.slave bus
);

  localparam int NUM_BLOCKS = NUM_CELLS / CELLS_PER_BLOCK;

  state_e             state_q, state_d;
  cmd_op_e            op_q, op_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]         ca_data_in_q, ca_data_in_d;
  logic               ca_we_n_q, ca_we_n_d;
  logic               ca_halt_n_q, ca_halt_n_d;
  logic [ADDR_W-1:0]  ca_addr_q, ca_addr_d;
  logic [7:0]         m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;

  logic              idx_clr, idx_inc, idx_last;
  logic [ADDR_W-1:0] idx;
  logic              cmd_fire, s_fire, m_fire;

  rule110_block_seq #(.NUM_BLOCKS(NUM_BLOCKS)) u_block_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (idx_clr),
    .inc_i  (idx_inc),
    .idx_o  (idx),
    .last_o (idx_last)
  );

  assign cmd_fire = bus.cmd_valid && (state_q == ST_IDLE);
  assign s_fire   = bus.s_valid && (state_q == ST_LOAD);
  assign m_fire   = m_valid_q && bus.m_ready && (state_q == ST_DUMP_HOLD);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    ca_data_in_d = ca_data_in_q;
    ca_we_n_d    = 1'b1;
    ca_halt_n_d  = 1'b0;
    ca_addr_d    = ca_addr_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    idx_clr      = 1'b0;
    idx_inc      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          op_d    = cmd_op_e'(bus.cmd_op);
          cnt_d   = bus.cmd_count;
          idx_clr = 1'b1;
          unique case (cmd_op_e'(bus.cmd_op))
            OP_LOAD: state_d = ST_LOAD;
            OP_DUMP: begin
              state_d   = ST_DUMP_ADDR;
              ca_addr_d = '0;
            end
            OP_STEP, OP_STEP_DUMP: begin
              // halt_n is registered, so it must rise on the same edge that enters STEP_RUN.
              if (bus.cmd_count != '0) begin
                state_d     = ST_STEP_RUN;
                ca_halt_n_d = 1'b1;
              end else if (cmd_op_e'(bus.cmd_op) == OP_STEP_DUMP) begin
                state_d   = ST_DUMP_ADDR;
                ca_addr_d = '0;
              end
            end
          endcase
        end
      end

      ST_LOAD: begin
        if (s_fire) begin
          ca_data_in_d = bus.s_data;
          ca_addr_d    = idx;
          ca_we_n_d    = 1'b0;
          if (idx_last) state_d = ST_IDLE;
          else          idx_inc = 1'b1;
        end
      end

      ST_STEP_RUN: begin
        cnt_d = cnt_q - COUNT_W'(1);
        if (cnt_q <= COUNT_W'(1)) begin
          state_d   = (op_q == OP_STEP_DUMP) ? ST_DUMP_ADDR : ST_IDLE;
          ca_addr_d = '0;
        end else begin
          ca_halt_n_d = 1'b1;
        end
      end

      ST_DUMP_ADDR: begin
        state_d   = ST_DUMP_HOLD;
        m_data_d  = bus.ca_data_out;
        m_valid_d = 1'b1;
        m_last_d  = idx_last;
      end

      ST_DUMP_HOLD: begin
        if (m_fire) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (idx_last) begin
            state_d = ST_IDLE;
          end else begin
            idx_inc   = 1'b1;
            ca_addr_d = idx + ADDR_W'(1);
            state_d   = ST_DUMP_ADDR;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_LOAD;
      cnt_q        <= '0;
      ca_data_in_q <= '0;
      ca_we_n_q    <= 1'b1;
      ca_halt_n_q  <= 1'b0;
      ca_addr_q    <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      ca_data_in_q <= ca_data_in_d;
      ca_we_n_q    <= ca_we_n_d;
      ca_halt_n_q  <= ca_halt_n_d;
      ca_addr_q    <= ca_addr_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.s_ready    = (state_q == ST_LOAD);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;
  assign bus.ca_data_in = ca_data_in_q;
  assign bus.ca_we_n    = ca_we_n_q;
  assign bus.ca_halt_n  = ca_halt_n_q;
  assign bus.ca_addr    = ca_addr_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: doc/rule110_host_ctrl.md
Name: rule110_host_ctrl

Overview:
Host-side sequencer that drives the rule110 automaton's pin interface (data_in, write_enable_n, halt_n, block address) and consumes its block-wide data_out.
- Converts a command port plus valid/ready byte streams into pin-level LOAD, STEP and DUMP sequences.
- Upstream: a host or serial bridge supplies a full frame of cell bytes.
- Downstream: a consumer receives snapshots of every block.

Parameters:
NUM_CELLS, 224, automaton width; must be a multiple of CELLS_PER_BLOCK.
CELLS_PER_BLOCK, 8, cells per addressable block (fixed by the pin map).
NUM_BLOCKS, NUM_CELLS/CELLS_PER_BLOCK (28), derived localparam; must be 1..63.
ADDR_W, 6, block address width.
COUNT_W, 16, step-count width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid (high only in IDLE)
cmd_op  in  2  00 LOAD, 01 STEP, 10 DUMP, 11 STEP_DUMP
cmd_count  in  COUNT_W  generations to advance (STEP/STEP_DUMP)
s_data  in  8  load byte, bit0 = lowest cell of block
s_valid  in  1  load byte valid
s_ready  out  1  load byte accepted
m_data  out  8  dumped block byte
m_valid  out  1  dump byte valid
m_ready  in  1  consumer ready
m_last  out  1  marks block NUM_BLOCKS-1
busy  out  1  state != IDLE
ca_data_in  out  8  to automaton data_in
ca_we_n  out  1  to automaton write_enable_n
ca_halt_n  out  1  to automaton halt_n
ca_addr  out  ADDR_W  to automaton address_in
ca_data_out  in  8  from automaton data_out (combinational on ca_addr)

Behaviour:
- Reset values: ca_we_n=1, ca_halt_n=0, ca_addr=0, ca_data_in=0, m_valid=0, m_last=0, m_data=0, s_ready=0, busy=0. cmd_ready=1 once reset is released.
- Reset mid-operation aborts any sequence immediately.
- All ca_* outputs are registered. ca_halt_n=0 in every state except STEP_RUN. The controller never drives ca_addr above NUM_BLOCKS-1.
- FSM states: IDLE, LOAD, STEP_RUN, DUMP_ADDR, DUMP_HOLD.
- IDLE:
  - On cmd_valid&&cmd_ready, latch cmd_op and cmd_count, clear block index idx.
  - LOAD -> LOAD; STEP and STEP_DUMP -> STEP_RUN; DUMP -> DUMP_ADDR.
  - STEP or STEP_DUMP with count 0 skips STEP_RUN (STEP returns to IDLE next cycle, STEP_DUMP goes to DUMP_ADDR).
- LOAD:
  - s_ready=1.
  - On accept: next cycle ca_data_in=s_data, ca_addr=idx, ca_we_n=0 for exactly one cycle, then idx++.
  - Accepts back-to-back bytes, one per cycle.
  - An s_valid gap leaves ca_we_n=1; the controller waits indefinitely.
  - After the write of byte NUM_BLOCKS-1: s_ready=0, return to IDLE.
  - Bytes offered outside LOAD are not accepted.
- STEP_RUN:
  - ca_halt_n=1, ca_we_n=1 for exactly cmd_count consecutive cycles, counted by a down-counter.
  - The automaton advances once per such cycle.
  - Then ca_halt_n=0; go to IDLE (STEP) or DUMP_ADDR (STEP_DUMP).
- DUMP_ADDR: drive ca_addr=idx for one cycle, so the automaton output settles.
- DUMP_HOLD:
  - On entry, capture m_data=ca_data_out; m_valid=1; m_last=(idx==NUM_BLOCKS-1).
  - Hold m_data, m_last and ca_addr stable while !m_ready.
  - On m_valid&&m_ready: m_valid=0; idx++ and go to DUMP_ADDR, or go to IDLE after the last block.
  - Throughput is 1 byte per 2 cycles maximum.
- Dumped bytes are the automaton's next-generation view as presented on data_out; the dump does not alter cell state, since halt_n=0 throughout.

Decomposition:
- Package rule110_pkg holds:
  - CELLS_PER_BLOCK and the default NUM_CELLS
  - ADDR_W
  - cmd_op encoding (OP_LOAD, OP_STEP, OP_DUMP, OP_STEP_DUMP)
  - FSM state encoding
- One sub-module, rule110_block_seq: the idx counter with clear, increment and last flag, shared by LOAD and DUMP.
- The step down-counter stays inline.

Test Plan:
1. Reset during STEP_RUN with cmd_count=1000 -> ca_halt_n=0, ca_we_n=1, ca_addr=0, busy=0 within the reset assertion; cmd_ready=1 after release.
2. LOAD with 28 back-to-back bytes 0x00..0x1B -> 28 single-cycle ca_we_n pulses, ca_addr 0..27 paired with ca_data_in 0x00..0x1B, then IDLE. Repeat with s_valid gaps: same sequence, no pulse during gaps.
3. STEP cmd_count=5 -> ca_halt_n high for exactly 5 cycles. STEP cmd_count=0 -> ca_halt_n never high, back to IDLE in 1 cycle.
4. DUMP against an automaton model loaded with a single 1 in cell 0 -> 28 bytes; block 0 byte equals the model's next-generation view of block 0; m_last only on byte 28.
5. DUMP with m_ready low for 7 cycles on byte 3 -> m_data, ca_addr and m_valid stable for those cycles; byte order intact.
6. STEP_DUMP cmd_count=1 from single cell 0 -> one halt_n=1 cycle, then a dump matching the model after 1 generation including wrap-around; cmd_valid during busy -> not accepted.
